// File: rtl/dfe_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// dfe_cfg_sequencer
//
// Purpose:
//   Run-time configuration sequencer for the DFE receive chain
//   (fractional decimator -> notch pair -> CIC). A requester offers a new CIC
//   decimation exponent k and a notch enable over a valid/ready handshake.
//   A real change waits for the next CIC output-sample boundary
//   (sample_strobe), or for a timeout if no boundary arrives. The new
//   configuration is then applied, and the downstream output is muted for a
//   fixed settle window while the filter and CIC state flush.
//
// Parameters:
//   SETTLE_CYCLES  cycles out_mute stays high after an apply (1..255)
//   ALIGN_TIMEOUT  max cycles spent waiting for sample_strobe (1..255)
//   DEFAULT_K      decimation exponent after reset (0..4)
//   DEFAULT_NOTCH  filter_enable after reset
//
// Ports:
//   CLK            in   system clock, rising edge
//   RST            in   synchronous active-high reset
//   cfg_valid      in   request present, held with a stable payload until accepted
//   cfg_ready      out  sequencer can accept a request (IDLE only)
//   cfg_k          in   requested exponent k, D = 2^k, legal 0..4
//   cfg_notch_en   in   requested notch enable
//   sample_strobe  in   one-cycle pulse on a CIC output-sample boundary
//   cic_dec_factor out  applied decimation factor D = 1 << k
//   filter_enable  out  applied notch enable
//   out_mute       out  downstream samples must be discarded while high
//   busy           out  high while a change is waiting or settling
//   cfg_err        out  one-cycle pulse after accepting a request with k > 4
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module dfe_cfg_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 64,
   parameter int unsigned ALIGN_TIMEOUT = 200,
   parameter int unsigned DEFAULT_K     = 0,
   parameter logic        DEFAULT_NOTCH = 1'b1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       cfg_valid,
   output logic       cfg_ready,
   input  logic [2:0] cfg_k,
   input  logic       cfg_notch_en,
   input  logic       sample_strobe,
   output logic [4:0] cic_dec_factor,
   output logic       filter_enable,
   output logic       out_mute,
   output logic       busy,
   output logic       cfg_err
);

   // Counter load/compare values, sized once to the 8-bit counter width.
   localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
   localparam logic [7:0] ALIGN_LAST  = 8'(ALIGN_TIMEOUT - 1);
   localparam logic [4:0] DEFAULT_D   = 5'(1 << DEFAULT_K);

   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_WAIT_ALIGN = 2'd1,
      S_SETTLE     = 2'd2
   } state_t;

   state_t     r_state,      w_state_next;
   logic [7:0] r_align_cnt,  w_align_cnt_next;
   logic [7:0] r_settle_cnt, w_settle_cnt_next;
   logic [4:0] r_pend_d,     w_pend_d_next;
   logic       r_pend_notch, w_pend_notch_next;
   logic [4:0] r_dec_factor, w_dec_factor_next;
   logic       r_filter_en,  w_filter_en_next;
   logic       r_mute,       w_mute_next;
   logic       r_busy,       w_busy_next;
   logic       r_err,        w_err_next;
   logic       r_ready,      w_ready_next;

   // Requested k decoded straight into the one-hot factor D = 1 << k.
   // An illegal k (5..7) decodes to all zeros, which doubles as the
   // legality check.
   logic [4:0] w_req_d;
   logic       w_req_legal;
   logic       w_req_same;
   logic       w_accept;

   genvar gi;
   generate
      for (gi = 0; gi < 5; gi++) begin : g_kdec
         assign w_req_d[gi] = (cfg_k == 3'(gi));
      end
   endgenerate

   assign w_req_legal = |w_req_d;
   assign w_req_same  = (w_req_d == r_dec_factor) && (cfg_notch_en == r_filter_en);
   assign w_accept    = cfg_valid && r_ready;

   // Next-state and next-output logic.
   always_comb begin
      w_state_next      = r_state;
      w_align_cnt_next  = r_align_cnt;
      w_settle_cnt_next = r_settle_cnt;
      w_pend_d_next     = r_pend_d;
      w_pend_notch_next = r_pend_notch;
      w_dec_factor_next = r_dec_factor;
      w_filter_en_next  = r_filter_en;
      w_mute_next       = r_mute;
      w_err_next        = 1'b0;
      w_busy_next       = 1'b0;
      w_ready_next      = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (!w_req_legal) begin
                  // Consumed, flagged, and nothing else changes.
                  w_err_next = 1'b1;
               end else if (!w_req_same) begin
                  // The pending factor is kept already decoded, so the
                  // apply step is a plain register copy.
                  w_pend_d_next     = w_req_d;
                  w_pend_notch_next = cfg_notch_en;
                  w_align_cnt_next  = 8'd0;
                  w_state_next      = S_WAIT_ALIGN;
               end
               // A legal request equal to the applied config is a no-op.
            end
         end

         S_WAIT_ALIGN: begin
            // A strobe in the accepting cycle is never seen here, because
            // this state is only entered at that edge.
            if (sample_strobe || (r_align_cnt == ALIGN_LAST)) begin
               w_dec_factor_next = r_pend_d;
               w_filter_en_next  = r_pend_notch;
               w_mute_next       = 1'b1;
               w_settle_cnt_next = SETTLE_LOAD;
               w_state_next      = S_SETTLE;
            end else begin
               w_align_cnt_next = r_align_cnt + 8'd1;
            end
         end

         S_SETTLE: begin
            // The counter is loaded with SETTLE_CYCLES-1 and exits on the
            // edge after it reaches zero. Mute therefore stays high for
            // exactly SETTLE_CYCLES cycles.
            if (r_settle_cnt == 8'd0) begin
               w_mute_next  = 1'b0;
               w_state_next = S_IDLE;
            end else begin
               w_settle_cnt_next = r_settle_cnt - 8'd1;
            end
         end

         default: begin
            w_mute_next  = 1'b0;
            w_state_next = S_IDLE;
         end
      endcase

      // The handshake and status flags follow the state being entered, so
      // they stay aligned with the registered state.
      w_ready_next = (w_state_next == S_IDLE);
      w_busy_next  = (w_state_next != S_IDLE);
   end

   // State and output registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state      <= S_IDLE;
         r_align_cnt  <= 8'd0;
         r_settle_cnt <= 8'd0;
         r_pend_d     <= DEFAULT_D;
         r_pend_notch <= DEFAULT_NOTCH;
         r_dec_factor <= DEFAULT_D;
         r_filter_en  <= DEFAULT_NOTCH;
         r_mute       <= 1'b0;
         r_busy       <= 1'b0;
         r_err        <= 1'b0;
         r_ready      <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_align_cnt  <= w_align_cnt_next;
         r_settle_cnt <= w_settle_cnt_next;
         r_pend_d     <= w_pend_d_next;
         r_pend_notch <= w_pend_notch_next;
         r_dec_factor <= w_dec_factor_next;
         r_filter_en  <= w_filter_en_next;
         r_mute       <= w_mute_next;
         r_busy       <= w_busy_next;
         r_err        <= w_err_next;
         r_ready      <= w_ready_next;
      end
   end

   assign cfg_ready      = r_ready;
   assign cic_dec_factor = r_dec_factor;
   assign filter_enable  = r_filter_en;
   assign out_mute       = r_mute;
   assign busy           = r_busy;
   assign cfg_err        = r_err;

endmodule
